// File: rtl/ysyx_22050019_hazard_sb.sv
// Operand forwarding, load scoreboard and outstanding-load limiter for the ID stage.
// Optional perf counters are compiled in with YSYX_22050019_HAZARD_PERF_EN.
module ysyx_22050019_hazard_slot #(
  parameter int XLEN   = 64,
  parameter int NR_FWD = 2
) (
  input  logic [4:0]                   raddr,
  input  logic [XLEN-1:0]              rdata,
  input  logic [NR_FWD-1:0]            fwd_valid,
  input  logic [NR_FWD-1:0][4:0]       fwd_waddr,
  input  logic [NR_FWD-1:0][XLEN-1:0]  fwd_wdata,
  input  logic [NR_FWD-1:0]            fwd_data_ok,
  input  logic                         pend_hit,
  input  logic                         ld_hit,
  input  logic [XLEN-1:0]              ld_wdata,
  output logic [XLEN-1:0]              operand,
  output logic                         hazard
);
  logic            hit, hit_ok;
  logic [XLEN-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_data = '0;
    // Scan oldest to youngest so the youngest matching stage is the last write.
    for (int k = NR_FWD-1; k >= 0; k--) begin
      if (fwd_valid[k] && fwd_waddr[k] == raddr) begin
        hit      = 1'b1;
        hit_ok   = fwd_data_ok[k];
        hit_data = fwd_wdata[k];
      end
    end
    operand = rdata;
    hazard  = 1'b0;
    if (raddr == 5'd0) begin
      operand = '0;
    end else if (hit) begin
      if (hit_ok) operand = hit_data;
      else        hazard  = 1'b1;
    end else if (pend_hit) begin
      if (ld_hit) operand = ld_wdata;
      else        hazard  = 1'b1;
    end
  end
endmodule

module ysyx_22050019_hazard_sb #(
  parameter int XLEN    = 64,
  parameter int NR_SRC  = 2,
  parameter int NR_FWD  = 2,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid_i,
  input  logic                     id_fire_i,
  input  logic [NR_SRC*5-1:0]      id_raddr_i,
  input  logic [NR_SRC*XLEN-1:0]   id_rdata_i,
  input  logic                     id_wen_i,
  input  logic                     id_is_load_i,
  input  logic [4:0]               id_waddr_i,
  input  logic [NR_FWD-1:0]        fwd_valid_i,
  input  logic [NR_FWD*5-1:0]      fwd_waddr_i,
  input  logic [NR_FWD*XLEN-1:0]   fwd_wdata_i,
  input  logic [NR_FWD-1:0]        fwd_data_ok_i,
  input  logic                     ld_done_i,
  input  logic [4:0]               ld_waddr_i,
  input  logic [XLEN-1:0]          ld_wdata_i,
  input  logic                     flush_i,
  output logic [NR_SRC*XLEN-1:0]   fwd_rdata_o,
  output logic                     stall_o,
  output logic [31:0]              pend_o,
  output logic [3:0]               out_cnt_o,
  output logic [31:0]              perf_stall_o,
  output logic [31:0]              perf_lduse_o
);
  localparam logic [3:0] MAX_C = 4'(MAX_OUT);

  logic [NR_SRC-1:0][4:0]       raddr;
  logic [NR_SRC-1:0][XLEN-1:0]  rdata, operand;
  logic [NR_FWD-1:0][4:0]       fwd_waddr;
  logic [NR_FWD-1:0][XLEN-1:0]  fwd_wdata;
  logic [NR_SRC-1:0]            hazard, pend_hit, ld_hit;
  logic [31:0]                  pend, pend_nxt;
  logic [3:0]                   cnt, cnt_nxt;
  logic                         issue, dec;

  assign raddr       = id_raddr_i;
  assign rdata       = id_rdata_i;
  assign fwd_waddr   = fwd_waddr_i;
  assign fwd_wdata   = fwd_wdata_i;
  assign fwd_rdata_o = operand;

  for (genvar s = 0; s < NR_SRC; s++) begin : g_slot
    assign pend_hit[s] = pend[raddr[s]];
    assign ld_hit[s]   = ld_done_i && (ld_waddr_i == raddr[s]);
    ysyx_22050019_hazard_slot #(.XLEN(XLEN), .NR_FWD(NR_FWD)) u_slot (
      .raddr(raddr[s]), .rdata(rdata[s]),
      .fwd_valid(fwd_valid_i), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
      .fwd_data_ok(fwd_data_ok_i), .pend_hit(pend_hit[s]), .ld_hit(ld_hit[s]),
      .ld_wdata(ld_wdata_i), .operand(operand[s]), .hazard(hazard[s])
    );
  end

  // A returning load frees a slot this cycle, so a full counter only blocks without it.
  assign stall_o = id_valid_i && ((|hazard) ||
                   (id_is_load_i && cnt == MAX_C && !ld_done_i));

  assign issue = id_fire_i && id_wen_i && id_is_load_i && !flush_i;
  assign dec   = ld_done_i && cnt != 4'd0;

  always_comb begin
    pend_nxt = pend;
    if (ld_done_i) pend_nxt[ld_waddr_i] = 1'b0;
    if (issue && id_waddr_i != 5'd0) pend_nxt[id_waddr_i] = 1'b1;
    cnt_nxt = cnt;
    if (issue && !dec && cnt != MAX_C) cnt_nxt = cnt + 4'd1;
    else if (dec && !issue)            cnt_nxt = cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign pend_o    = pend;
  assign out_cnt_o = cnt;

`ifdef YSYX_22050019_HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_lduse;
  logic        hz_stall, hz_q;
  assign hz_stall = id_valid_i && (|hazard);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= '0;
      perf_lduse <= '0;
      hz_q       <= 1'b0;
    end else begin
      perf_stall <= perf_stall + {31'd0, stall_o};
      if (hz_stall && !hz_q) perf_lduse <= perf_lduse + 32'd1;
      hz_q <= hz_stall;
    end
  end
  assign perf_stall_o = perf_stall;
  assign perf_lduse_o = perf_lduse;
`else
  assign perf_stall_o = '0;
  assign perf_lduse_o = '0;
`endif
endmodule

// File: tb/tb_ysyx_22050019_hazard_sb.sv
// Directed and randomized checks of ysyx_22050019_hazard_sb against a behavioural model.
module tb_ysyx_22050019_hazard_sb;
  localparam int XLEN = 64, NR_SRC = 2, NR_FWD = 2, MAX_OUT = 2;

  logic clk, rst, id_valid, id_fire, id_wen, id_is_load, ld_done, flush, stall;
  logic [NR_SRC*5-1:0]    id_raddr;
  logic [NR_SRC*XLEN-1:0] id_rdata, fwd_rdata;
  logic [4:0]             id_waddr, ld_waddr;
  logic [NR_FWD-1:0]      fwd_valid, fwd_data_ok;
  logic [NR_FWD*5-1:0]    fwd_waddr;
  logic [NR_FWD*XLEN-1:0] fwd_wdata;
  logic [XLEN-1:0]        ld_wdata;
  logic [31:0]            pend, perf_stall, perf_lduse;
  logic [3:0]             out_cnt;

  ysyx_22050019_hazard_sb #(.XLEN(XLEN), .NR_SRC(NR_SRC), .NR_FWD(NR_FWD), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_fire_i(id_fire),
    .id_raddr_i(id_raddr), .id_rdata_i(id_rdata), .id_wen_i(id_wen),
    .id_is_load_i(id_is_load), .id_waddr_i(id_waddr), .fwd_valid_i(fwd_valid),
    .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata), .fwd_data_ok_i(fwd_data_ok),
    .ld_done_i(ld_done), .ld_waddr_i(ld_waddr), .ld_wdata_i(ld_wdata), .flush_i(flush),
    .fwd_rdata_o(fwd_rdata), .stall_o(stall), .pend_o(pend), .out_cnt_o(out_cnt),
    .perf_stall_o(perf_stall), .perf_lduse_o(perf_lduse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0, total = 0;
  logic [31:0]     pend_m;
  int              cnt_m;
  logic [XLEN-1:0] exp_op [NR_SRC];
  bit              exp_hz [NR_SRC];
  bit              exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_in();
    id_valid = 0; id_fire = 0; id_wen = 0; id_is_load = 0; id_waddr = 0;
    id_raddr = '0; id_rdata = '0; fwd_valid = '0; fwd_waddr = '0; fwd_wdata = '0;
    fwd_data_ok = '0; ld_done = 0; ld_waddr = 0; ld_wdata = '0; flush = 0;
  endtask

  // Operands follow the resolution order: x0, youngest stage, pending load, regfile.
  task automatic model_eval();
    bit hz = 0;
    for (int s = 0; s < NR_SRC; s++) begin
      logic [4:0] a = id_raddr[5*s +: 5];
      bit found = 0;
      exp_hz[s] = 0;
      exp_op[s] = id_rdata[XLEN*s +: XLEN];
      if (a == 0) exp_op[s] = '0;
      else begin
        for (int k = 0; k < NR_FWD; k++)
          if (!found && fwd_valid[k] && fwd_waddr[5*k +: 5] == a) begin
            found = 1;
            if (fwd_data_ok[k]) exp_op[s] = fwd_wdata[XLEN*k +: XLEN];
            else exp_hz[s] = 1;
          end
        if (!found && pend_m[a]) begin
          if (ld_done && ld_waddr == a) exp_op[s] = ld_wdata;
          else exp_hz[s] = 1;
        end
      end
      hz |= exp_hz[s];
    end
    exp_stall = id_valid && (hz || (id_is_load && cnt_m == MAX_OUT && !ld_done));
  endtask

  task automatic check_cycle();
    model_eval();
    chk("stall", {63'd0, stall}, {63'd0, exp_stall});
    for (int s = 0; s < NR_SRC; s++)
      if (!exp_hz[s]) chk($sformatf("operand%0d", s), fwd_rdata[XLEN*s +: XLEN], exp_op[s]);
    chk("pend", {32'd0, pend}, {32'd0, pend_m});
    chk("out_cnt", {60'd0, out_cnt}, 64'(cnt_m));
    chk("perf_stall", {32'd0, perf_stall}, 64'd0);
  endtask

  task automatic tick();
    bit iss = id_fire && id_wen && id_is_load && !flush;
    @(posedge clk);
    if (ld_done) pend_m[ld_waddr] = 1'b0;
    if (iss && id_waddr != 0) pend_m[id_waddr] = 1'b1;
    if (iss && ld_done && cnt_m > 0) cnt_m = cnt_m;
    else if (iss) cnt_m = (cnt_m < MAX_OUT) ? cnt_m + 1 : MAX_OUT;
    else if (ld_done && cnt_m > 0) cnt_m = cnt_m - 1;
    #1;
  endtask

  initial begin
    clear_in();
    pend_m = '0; cnt_m = 0;
    rst = 1'b1;
    #13 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state: regfile values pass straight through.
    id_raddr = {5'd6, 5'd5};
    id_rdata = {64'h22, 64'h11};
    #1 check_cycle();
    chk("rst_op0", fwd_rdata[63:0], 64'h11);
    chk("rst_op1", fwd_rdata[127:64], 64'h22);
    chk("rst_stall", {63'd0, stall}, 64'd0);

    // Youngest stage wins; x0 is never forwarded.
    fwd_valid = 2'b11; fwd_waddr = {5'd5, 5'd5}; fwd_wdata = {64'hAA, 64'hBB};
    fwd_data_ok = 2'b11; id_raddr = {5'd0, 5'd5}; id_valid = 1;
    #1 check_cycle();
    chk("young_op0", fwd_rdata[63:0], 64'hBB);
    fwd_waddr = {5'd0, 5'd0}; id_raddr = 10'd0;
    #1 check_cycle();
    chk("x0_op0", fwd_rdata[63:0], 64'd0);
    tick();

    // Load to x7 then a consumer while its data is not yet final.
    clear_in(); id_valid = 1; id_is_load = 1; id_wen = 1; id_waddr = 7; id_fire = 1;
    #1 check_cycle(); tick();
    clear_in(); id_valid = 1; fwd_valid = 2'b01; fwd_waddr = {5'd0, 5'd7}; id_raddr = {5'd0, 5'd7};
    #1 check_cycle();
    chk("lduse_stall", {63'd0, stall}, 64'd1);
    chk("pend7", {63'd0, pend[7]}, 64'd1);
    fwd_data_ok = 2'b01; fwd_wdata = {64'd0, 64'h1234};
    #1 check_cycle();
    chk("lduse_fwd", fwd_rdata[63:0], 64'h1234);
    chk("lduse_clear", {63'd0, stall}, 64'd0);
    tick();

    // Fill the outstanding-load budget with x9, then consume x9 via the return bypass.
    clear_in(); id_valid = 1; id_is_load = 1; id_wen = 1; id_waddr = 9; id_fire = 1;
    #1 check_cycle(); tick();
    clear_in(); id_valid = 1; id_is_load = 1; id_wen = 1; id_waddr = 3; id_raddr = {5'd9, 5'd0};
    #1 check_cycle();
    chk("full_stall", {63'd0, stall}, 64'd1);
    ld_done = 1; ld_waddr = 9; ld_wdata = 64'h55;
    #1 check_cycle();
    chk("ld_bypass", fwd_rdata[127:64], 64'h55);
    id_fire = 1;
    tick();
    chk("cnt_hold", {60'd0, out_cnt}, 64'd2);
    chk("pend9_clr", {63'd0, pend[9]}, 64'd0);
    // Same-cycle clear and set of x3: set wins.
    clear_in(); id_valid = 1; id_is_load = 1; id_wen = 1; id_waddr = 3; id_fire = 1;
    ld_done = 1; ld_waddr = 3;
    #1 check_cycle(); tick();
    chk("pend3_set", {63'd0, pend[3]}, 64'd1);

    // Asynchronous reset between clock edges.
    clear_in();
    #2 rst = 1'b1;
    #1 chk("arst_pend", {32'd0, pend}, 64'd0);
    chk("arst_cnt", {60'd0, out_cnt}, 64'd0);
    pend_m = '0; cnt_m = 0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Flushed load issue leaves the scoreboard untouched.
    id_valid = 1; id_is_load = 1; id_wen = 1; id_waddr = 4; id_fire = 1; flush = 1;
    #1 check_cycle(); tick();
    chk("flush_pend", {32'd0, pend}, 64'd0);
    chk("flush_cnt", {60'd0, out_cnt}, 64'd0);

    for (int n = 0; n < 400; n++) begin
      clear_in();
      id_valid = $urandom_range(0, 3) != 0;
      id_is_load = $urandom_range(0, 1);
      id_wen = $urandom_range(0, 3) != 0;
      id_waddr = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 9) == 0;
      for (int s = 0; s < NR_SRC; s++) begin
        id_raddr[5*s +: 5] = 5'($urandom_range(0, 7));
        id_rdata[XLEN*s +: XLEN] = {$urandom, $urandom};
      end
      for (int k = 0; k < NR_FWD; k++) begin
        fwd_valid[k] = $urandom_range(0, 2) == 0;
        fwd_waddr[5*k +: 5] = 5'($urandom_range(0, 7));
        fwd_wdata[XLEN*k +: XLEN] = {$urandom, $urandom};
        fwd_data_ok[k] = $urandom_range(0, 3) != 0;
      end
      if ((cnt_m > 0 && $urandom_range(0, 2) == 0) || $urandom_range(0, 19) == 0) begin
        int st = $urandom_range(0, 31);
        ld_done = 1;
        ld_waddr = 5'($urandom_range(0, 7));
        for (int r = 0; r < 32; r++)
          if (pend_m[(st + r) % 32]) ld_waddr = 5'((st + r) % 32);
        ld_wdata = {$urandom, $urandom};
      end
      #1 check_cycle();
      id_fire = id_valid && !exp_stall && ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
